prog_counter: RTL and testbench

//   Parametrised free-running/loadable counter: configurable width, prescaler,
//   up/down direction, wrap or saturate at limits, terminal-count pulse and

---
 rtl/prog_counter.sv | 142 ++++++++++++++
 tb/tb_prog_counter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
//   General-purpose counter/timer primitive. It counts up or down, can be
//   cleared or loaded, and has an optional prescaler. At a limit it either
//   wraps or holds, and it reports terminal count with a pulse and with a
//   sticky flag.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   PRESCALE  enabled cycles per count step (>= 1, 1 = step every enabled cycle)
//   SATURATE  0 = wrap at the limit, 1 = hold at the limit
//   RST_VAL   value of out after reset and after clr
//
// Ports
//   clk       in   1      clock; all logic uses the rising edge
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      count enable; gates both the prescaler and the counter
//   clr       in   1      synchronous clear to RST_VAL (highest priority)
//   load      in   1      synchronous load of load_val (below clr)
//   load_val  in   WIDTH  value taken by load
//   dir       in   1      1 = count up, 0 = count down
//   out       out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse, high the cycle after a tick at the limit
//   ovf       out  1      sticky; set by any terminal count, cleared only by clr
//   cmp_val   in   WIDTH  compare value             (PROG_COUNTER_CMP_EN only)
//   cmp_hit   out  1      registered compare pulse  (PROG_COUNTER_CMP_EN only)
//
// Build option
//   PROG_COUNTER_CMP_EN : when this macro is defined, the comparator and its two
//   ports are present. cmp_hit goes high for one cycle, in step with out, when a
//   tick, load or clr gives out a new value equal to cmp_val.
// -----------------------------------------------------------------------------
module prog_counter #(
   parameter int               WIDTH    = 32,
   parameter int               PRESCALE = 1,
   parameter int               SATURATE = 0,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             ovf
`ifdef PROG_COUNTER_CMP_EN
   ,
   input  logic [WIDTH-1:0] cmp_val,
   output logic             cmp_hit
`endif
);

   // The prescaler needs at least one bit. With PRESCALE == 1 it stays at 0,
   // so every enabled cycle produces a tick.
   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [PW-1:0]    pre;
   logic             tick;
   logic [WIDTH-1:0] limit;
   logic             at_limit;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] next_out;
   logic             out_update;

   // A count step happens only on an enabled cycle that ends a prescale period.
   assign tick     = en && (pre == PRE_LAST);

   // The limit depends on the direction that is sampled on this tick.
   assign limit    = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
   assign at_limit = (out == limit);

   // Modulo-2^WIDTH arithmetic gives the wrap for free: max+1 -> 0 and 0-1 -> max.
   assign step_val = dir ? (out + ONE) : (out - ONE);

   // Value out takes at the next edge, in priority order clr > load > tick.
   // The comparator shares this value, so it tests exactly what out becomes.
   always_comb begin
      next_out   = out;
      out_update = 1'b0;
      if (clr) begin
         next_out   = RST_VAL;
         out_update = 1'b1;
      end else if (load) begin
         next_out   = load_val;
         out_update = 1'b1;
      end else if (tick) begin
         out_update = 1'b1;
         if (at_limit && (SATURATE != 0))
            next_out = out;
         else
            next_out = step_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= RST_VAL;
         pre <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         out <= next_out;

         // clr and load restart the prescale period. en=0 freezes it.
         if (clr || load)
            pre <= '0;
         else if (en)
            pre <= tick ? '0 : (pre + PRE_ONE);

         // tc is high for a single cycle after each tick at the limit. While
         // the counter sits saturated at the limit with PRESCALE=1, every cycle
         // is such a tick, so tc stays high.
         tc <= !clr && !load && tick && at_limit;

         // ovf is sticky. Only clr clears it; load leaves it unchanged.
         if (clr)
            ovf <= 1'b0;
         else if (!load && tick && at_limit)
            ovf <= 1'b1;
      end
   end

`ifdef PROG_COUNTER_CMP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cmp_hit <= 1'b0;
      else
         cmp_hit <= out_update && (next_out == cmp_val);
   end
`else
   // Without the comparator, out_update has no reader.
   logic unused_update;
   assign unused_update = out_update;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// -----------------------------------------------------------------------------
// tb_prog_counter
//   Three instances of prog_counter run side by side on the same control inputs:
//     dut_a : WIDTH=8, PRESCALE=1, wrap,     RST_VAL=8'h00
//     dut_b : WIDTH=4, PRESCALE=1, saturate, RST_VAL=4'h0
//     dut_c : WIDTH=8, PRESCALE=3, wrap,     RST_VAL=8'h3C
//   A reference model works out each instance's expected state from the
//   counter rules using integer arithmetic.
// -----------------------------------------------------------------------------
module tb_prog_counter;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       en       = 1'b0;
   logic       clr      = 1'b0;
   logic       load     = 1'b0;
   logic       dir      = 1'b1;
   logic [7:0] load_val = 8'h00;
   logic [7:0] cmp_val  = 8'h10;

   logic [7:0] out_a, out_c;
   logic [3:0] out_b;
   logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;
   logic       hit_a, hit_b, hit_c;

   prog_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(0), .RST_VAL(8'h00)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .dir(dir), .out(out_a), .tc(tc_a), .ovf(ovf_a)
`ifdef PROG_COUNTER_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_a)
`endif
   );

   prog_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1), .RST_VAL(4'h0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val[3:0]), .dir(dir), .out(out_b), .tc(tc_b), .ovf(ovf_b)
`ifdef PROG_COUNTER_CMP_EN
      , .cmp_val(cmp_val[3:0]), .cmp_hit(hit_b)
`endif
   );

   prog_counter #(.WIDTH(8), .PRESCALE(3), .SATURATE(0), .RST_VAL(8'h3C)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .dir(dir), .out(out_c), .tc(tc_c), .ovf(ovf_c)
`ifdef PROG_COUNTER_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_c)
`endif
   );

`ifndef PROG_COUNTER_CMP_EN
   assign hit_a = 1'b0;
   assign hit_b = 1'b0;
   assign hit_c = 1'b0;
`endif

   // Actual outputs gathered into arrays so the model can be compared in a loop.
   logic [31:0] act_out[3];
   logic        act_tc[3], act_ovf[3], act_hit[3];
   always_comb begin
      act_out[0] = {24'b0, out_a};
      act_out[1] = {28'b0, out_b};
      act_out[2] = {24'b0, out_c};
      act_tc[0]  = tc_a;  act_tc[1]  = tc_b;  act_tc[2]  = tc_c;
      act_ovf[0] = ovf_a; act_ovf[1] = ovf_b; act_ovf[2] = ovf_c;
      act_hit[0] = hit_a; act_hit[1] = hit_b; act_hit[2] = hit_c;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int p_w[3]   = '{8, 4, 8};
   int p_pre[3] = '{1, 1, 3};
   int p_sat[3] = '{0, 1, 0};
   int p_rst[3] = '{0, 0, 'h3C};

   int m_out[3];
   int m_pre[3];
   bit m_tc[3];
   bit m_ovf[3];
   bit m_hit[3];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_out[i] = p_rst[i];
         m_pre[i] = 0;
         m_tc[i]  = 0;
         m_ovf[i] = 0;
         m_hit[i] = 0;
      end
   endtask

   task automatic model_step(input bit e, input bit c, input bit l, input int lv,
                             input bit d, input int cv);
      for (int i = 0; i < 3; i++) begin
         int  maxv;
         int  nv;
         bit  upd;
         maxv = (1 << p_w[i]) - 1;
         nv   = m_out[i];
         upd  = 0;
         if (c) begin
            nv = p_rst[i]; upd = 1; m_pre[i] = 0; m_ovf[i] = 0; m_tc[i] = 0;
         end else if (l) begin
            nv = lv & maxv; upd = 1; m_pre[i] = 0; m_tc[i] = 0;
         end else if (e && (m_pre[i] == p_pre[i] - 1)) begin
            upd = 1;
            m_pre[i] = 0;
            if (m_out[i] == (d ? maxv : 0)) begin
               m_tc[i]  = 1;
               m_ovf[i] = 1;
               nv = (p_sat[i] != 0) ? m_out[i] : (d ? 0 : maxv);
            end else begin
               m_tc[i] = 0;
               nv = d ? m_out[i] + 1 : m_out[i] - 1;
            end
         end else begin
            if (e) m_pre[i] = m_pre[i] + 1;
            m_tc[i] = 0;
         end
         m_hit[i] = upd && (nv == (cv & maxv));
         m_out[i] = nv;
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change on the falling edge. The model advances on the rising
   // edge, and the outputs are then valid 1 ns after that edge.
   task automatic drive(input bit e, input bit c, input bit l, input int lv, input bit d);
      @(negedge clk);
      en = e; clr = c; load = l; load_val = lv[7:0]; dir = d;
      @(posedge clk);
      if (rst_n) model_step(e, c, l, lv, d, int'(cmp_val));
      else       model_reset();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_tests++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL reset_out_a got %0h exp 00", out_a); end
      n_tests++; if (out_b !== 4'h0)  begin n_fail++; $display("FAIL reset_out_b got %0h exp 0", out_b); end
      n_tests++; if (out_c !== 8'h3C) begin n_fail++; $display("FAIL reset_out_c got %0h exp 3c", out_c); end
      n_tests++; if ({tc_a, tc_b, tc_c} !== 3'b000) begin n_fail++; $display("FAIL reset_tc got %b exp 000", {tc_a, tc_b, tc_c}); end
      n_tests++; if ({ovf_a, ovf_b, ovf_c} !== 3'b000) begin n_fail++; $display("FAIL reset_ovf got %b exp 000", {ovf_a, ovf_b, ovf_c}); end
      n_tests++; if ({hit_a, hit_b, hit_c} !== 3'b000) begin n_fail++; $display("FAIL reset_hit got %b exp 000", {hit_a, hit_b, hit_c}); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_wrap();
      for (int k = 1; k <= 256; k++) begin
         drive(1, 0, 0, 0, 1);
         n_tests++; if (out_a !== 8'(k)) begin n_fail++; $display("FAIL wrap_out k=%0d got %0h exp %0h", k, out_a, 8'(k)); end
         n_tests++; if (tc_a !== (k == 256)) begin n_fail++; $display("FAIL wrap_tc k=%0d got %b exp %b", k, tc_a, (k == 256)); end
         n_tests++; if (ovf_a !== (k == 256)) begin n_fail++; $display("FAIL wrap_ovf k=%0d got %b exp %b", k, ovf_a, (k == 256)); end
      end
      drive(1, 0, 0, 0, 1);
      n_tests++; if (out_a !== 8'h01) begin n_fail++; $display("FAIL wrap_after_out got %0h exp 01", out_a); end
      n_tests++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL wrap_after_tc got %b exp 0", tc_a); end
      n_tests++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky_ovf got %b exp 1", ovf_a); end
   endtask

   task automatic test_saturate();
      logic [3:0] exp_o[4];
      logic       exp_t[4];
      exp_o = '{4'h1, 4'h0, 4'h0, 4'h0};
      exp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
      drive(0, 0, 1, 2, 0);
      n_tests++; if (out_b !== 4'h2) begin n_fail++; $display("FAIL sat_load got %0h exp 2", out_b); end
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0, 0, 0);
         n_tests++; if (out_b !== exp_o[k]) begin n_fail++; $display("FAIL sat_out k=%0d got %0h exp %0h", k, out_b, exp_o[k]); end
         n_tests++; if (tc_b !== exp_t[k]) begin n_fail++; $display("FAIL sat_tc k=%0d got %b exp %b", k, tc_b, exp_t[k]); end
      end
      n_tests++; if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got %b exp 1", ovf_b); end
      drive(0, 1, 0, 0, 0);
      n_tests++; if ({out_b, tc_b, ovf_b} !== 6'b0) begin n_fail++; $display("FAIL sat_clr got out=%0h tc=%b ovf=%b exp 0/0/0", out_b, tc_b, ovf_b); end
   endtask

   task automatic test_prescale();
      logic [7:0] exp_c;
      drive(0, 1, 0, 0, 1);
      n_tests++; if (out_c !== 8'h3C) begin n_fail++; $display("FAIL pre_clr got %0h exp 3c", out_c); end
      for (int k = 1; k <= 7; k++) begin
         drive(1, 0, 0, 0, 1);
         exp_c = 8'(8'h3C + k / 3);
         n_tests++; if (out_c !== exp_c) begin n_fail++; $display("FAIL pre_step k=%0d got %0h exp %0h", k, out_c, exp_c); end
      end
      // One count into the next prescale period; hold en low for 5 cycles.
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 0, 1);
         n_tests++; if (out_c !== 8'h3E) begin n_fail++; $display("FAIL pre_freeze k=%0d got %0h exp 3e", k, out_c); end
      end
      drive(1, 0, 0, 0, 1);
      n_tests++; if (out_c !== 8'h3E) begin n_fail++; $display("FAIL pre_resume1 got %0h exp 3e", out_c); end
      drive(1, 0, 0, 0, 1);
      n_tests++; if (out_c !== 8'h3F) begin n_fail++; $display("FAIL pre_resume2 got %0h exp 3f", out_c); end
   endtask

   task automatic test_clr_load();
      drive(1, 1, 1, 'hA5, 1);
      n_tests++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL clrload_a got %0h exp 00", out_a); end
      n_tests++; if (out_c !== 8'h3C) begin n_fail++; $display("FAIL clrload_c got %0h exp 3c", out_c); end
      drive(1, 0, 1, 'hA5, 1);
      n_tests++; if (out_a !== 8'hA5) begin n_fail++; $display("FAIL load_a got %0h exp a5", out_a); end
      n_tests++; if (out_b !== 4'h5)  begin n_fail++; $display("FAIL load_b got %0h exp 5", out_b); end
      n_tests++; if (out_c !== 8'hA5) begin n_fail++; $display("FAIL load_c got %0h exp a5", out_c); end
      drive(1, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 1);
      n_tests++; if (out_c !== 8'hA5) begin n_fail++; $display("FAIL load_pre_restart got %0h exp a5", out_c); end
      drive(1, 0, 0, 0, 1);
      n_tests++; if (out_c !== 8'hA6) begin n_fail++; $display("FAIL load_pre_tick got %0h exp a6", out_c); end
      n_tests++; if (out_a !== 8'hA8) begin n_fail++; $display("FAIL load_a_count got %0h exp a8", out_a); end
   endtask

   task automatic test_async_reset();
      drive(0, 0, 1, 'hFF, 1);
      drive(1, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 1);
      n_tests++; if ({out_a, ovf_a} !== {8'h01, 1'b1}) begin n_fail++; $display("FAIL arst_pre got out=%0h ovf=%b exp 01/1", out_a, ovf_a); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL arst_out_a got %0h exp 00", out_a); end
      n_tests++; if (out_c !== 8'h3C) begin n_fail++; $display("FAIL arst_out_c got %0h exp 3c", out_c); end
      n_tests++; if ({tc_a, ovf_a, ovf_b, ovf_c} !== 4'b0) begin n_fail++; $display("FAIL arst_flags got %b exp 0000", {tc_a, ovf_a, ovf_b, ovf_c}); end
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         drive(1, 0, 0, 0, 1);
         n_tests++; if (out_a !== 8'(k)) begin n_fail++; $display("FAIL arst_resume_a k=%0d got %0h exp %0h", k, out_a, 8'(k)); end
         n_tests++; if (out_c !== 8'(8'h3C + k / 3)) begin n_fail++; $display("FAIL arst_resume_c k=%0d got %0h exp %0h", k, out_c, 8'(8'h3C + k / 3)); end
      end
   endtask

   task automatic test_random();
      bit e, c, l, d;
      int lv;
      for (int k = 0; k < 600; k++) begin
         e = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 24) == 0);
         l = ($urandom_range(0, 15) == 0);
         if ((k % 40) == 0) d = $urandom_range(0, 1);
         case ($urandom_range(0, 4))
            0:       lv = 0;
            1:       lv = 'hFF;
            2:       lv = 'hFE;
            3:       lv = 1;
            default: lv = $urandom_range(0, 255);
         endcase
         drive(e, c, l, lv, d);
         for (int i = 0; i < 3; i++) begin
            n_tests++; if (act_out[i] !== 32'(m_out[i])) begin n_fail++; $display("FAIL rnd_out dut=%0d k=%0d got %0h exp %0h", i, k, act_out[i], m_out[i]); end
            n_tests++; if (act_tc[i] !== m_tc[i]) begin n_fail++; $display("FAIL rnd_tc dut=%0d k=%0d got %b exp %b", i, k, act_tc[i], m_tc[i]); end
            n_tests++; if (act_ovf[i] !== m_ovf[i]) begin n_fail++; $display("FAIL rnd_ovf dut=%0d k=%0d got %b exp %b", i, k, act_ovf[i], m_ovf[i]); end
`ifdef PROG_COUNTER_CMP_EN
            n_tests++; if (act_hit[i] !== m_hit[i]) begin n_fail++; $display("FAIL rnd_hit dut=%0d k=%0d got %b exp %b", i, k, act_hit[i], m_hit[i]); end
`endif
         end
      end
   endtask

`ifdef PROG_COUNTER_CMP_EN
   task automatic test_cmp();
      cmp_val = 8'h10;
      drive(0, 1, 0, 0, 1);
      n_tests++; if (hit_a !== 1'b0) begin n_fail++; $display("FAIL cmp_clr got %b exp 0", hit_a); end
      for (int k = 1; k <= 18; k++) begin
         drive(1, 0, 0, 0, 1);
         n_tests++; if (hit_a !== (k == 16)) begin n_fail++; $display("FAIL cmp_count k=%0d got %b exp %b", k, hit_a, (k == 16)); end
      end
      drive(0, 0, 1, 'h10, 1);
      n_tests++; if (hit_a !== 1'b1) begin n_fail++; $display("FAIL cmp_load got %b exp 1", hit_a); end
      drive(0, 0, 0, 0, 1);
      n_tests++; if (hit_a !== 1'b0) begin n_fail++; $display("FAIL cmp_load_pulse got %b exp 0", hit_a); end
   endtask
`endif

   initial begin
      test_reset();
      test_wrap();
      test_saturate();
      test_prescale();
      test_clr_load();
      test_async_reset();
`ifdef PROG_COUNTER_CMP_EN
      test_cmp();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
